// File: rtl/br_ckpt_ctrl_pkg.sv
// Shared types for the branch-checkpoint controller: tag/mask widths,
// the recovery FSM state encoding and the ROB entry view of a branch tag.
package br_ckpt_ctrl_pkg;

   localparam int CKPT_NUM   = 4;
   localparam int CKPT_TAG_W = $clog2(CKPT_NUM);

   typedef logic [CKPT_TAG_W-1:0] br_tag_t;
   typedef logic [CKPT_NUM-1:0]   ckpt_mask_t;

   typedef enum logic {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } ckpt_state_t;

   // ROB entry fields relevant to branch recovery; br_tag uses the checkpoint tag type
   typedef struct packed {
      logic       valid;
      logic       is_branch;
      logic [4:0] rd;
      br_tag_t    br_tag;
   } rob_info_t;

endpackage

// File: rtl/br_ckpt_ctrl_prio_enc_free.sv
// Lowest-set-bit finder over the free-slot vector; returns whether any
// slot is free and the index of the lowest free one (0 when none).
module prio_enc_free #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_free,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_free[i]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/br_ckpt_ctrl.sv
// Branch-checkpoint tag controller: hands out tags to dispatching branches,
// tracks relative age in a per-tag "older" matrix, frees tags on correct
// resolve and sequences flush + dispatch stall on a mispredict.
module br_ckpt_ctrl
   import br_ckpt_ctrl_pkg::*;
#(
   parameter int NUM_CKPT    = CKPT_NUM,
   parameter int TAG_W       = $clog2(NUM_CKPT),
   parameter int RECOVER_CYC = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                br_disp_req,
   output logic                br_disp_ready,
   output logic [TAG_W-1:0]    br_disp_tag,
   output logic                snapshot,
   input  logic                res_valid,
   input  logic [TAG_W-1:0]    res_tag,
   input  logic                res_mispredict,
   output logic                flush,
   output logic [TAG_W-1:0]    restore_tag,
   output logic [NUM_CKPT-1:0] kill_mask,
   output logic [NUM_CKPT-1:0] busy_mask,
   output logic                err
);

   localparam int CNT_W = $clog2(RECOVER_CYC) + 1;

   logic [NUM_CKPT-1:0] r_busy;
   // r_older[t] holds the set of tags allocated before tag t (still live)
   logic [NUM_CKPT-1:0] r_older [NUM_CKPT];
   ckpt_state_t         r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;

   logic                w_found;
   logic [TAG_W-1:0]    w_free_idx;
   logic [NUM_CKPT-1:0] w_free_vec;
   logic                w_res_hit;
   logic                w_mis_req;
   logic                w_mis;
   logic                w_cor;
   logic                w_err_ev;
   logic                w_ready;
   logic                w_fire;
   logic [NUM_CKPT-1:0] w_res_oh;
   logic [NUM_CKPT-1:0] w_alloc_oh;
   logic [NUM_CKPT-1:0] w_freed;
   logic [NUM_CKPT-1:0] w_kill;

   function automatic logic [NUM_CKPT-1:0] f_onehot(input logic [TAG_W-1:0] idx);
      logic [NUM_CKPT-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign w_free_vec = ~r_busy;

   prio_enc_free #(
      .N     (NUM_CKPT),
      .IDX_W (TAG_W)
   ) u_prio_enc_free (
      .i_free  (w_free_vec),
      .o_found (w_found),
      .o_idx   (w_free_idx)
   );

   assign w_res_hit  = r_busy[res_tag];
   assign w_mis_req  = res_valid && res_mispredict;
   assign w_mis      = w_mis_req && w_res_hit;
   assign w_cor      = res_valid && !res_mispredict && w_res_hit;
   // Resolves of free tags during recovery are late reports for killed branches
   assign w_err_ev   = res_valid && !w_res_hit && (r_state == IDLE);
   // A raw mispredict blocks dispatch even before we know it hits, so flush and snapshot never overlap
   assign w_ready    = w_found && (r_state == IDLE) && !w_mis_req;
   assign w_fire     = br_disp_req && w_ready;
   assign w_res_oh   = f_onehot(res_tag);
   assign w_alloc_oh = f_onehot(w_free_idx);
   assign w_freed    = w_cor ? w_res_oh : '0;

   // Kill set: the mispredicted tag plus every live tag younger than it
   always_comb begin
      w_kill = '0;
      if (w_mis) begin
         w_kill = w_res_oh;
         for (int t = 0; t < NUM_CKPT; t++) begin
            if (r_busy[t] && r_older[t][res_tag]) begin
               w_kill[t] = 1'b1;
            end
         end
      end
   end

   // Busy vector and age matrix: allocate, free on correct resolve, drop killed tags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         for (int t = 0; t < NUM_CKPT; t++) begin
            r_older[t] <= '0;
         end
      end else begin
         r_busy <= (r_busy & ~w_freed & ~w_kill) | (w_fire ? w_alloc_oh : '0);
         for (int t = 0; t < NUM_CKPT; t++) begin
            if (w_kill[t] || w_freed[t]) begin
               r_older[t] <= '0;
            end else if (w_fire && w_alloc_oh[t]) begin
               // The new branch is younger than everything still live after this cycle's free
               r_older[t] <= r_busy & ~w_freed;
            end else begin
               r_older[t] <= r_older[t] & ~w_freed;
            end
         end
      end
   end

   // Recovery FSM: a flush enters RECOVER, an older mispredict restarts the stall count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mis) begin
                  r_state <= RECOVER;
                  r_cnt   <= CNT_W'(RECOVER_CYC - 1);
               end
            end
            RECOVER: begin
               if (w_mis) begin
                  r_cnt <= CNT_W'(RECOVER_CYC - 1);
               end else if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Sticky error on a resolve that names an unallocated tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_err_ev) begin
         r_err <= 1'b1;
      end
   end

   assign br_disp_ready = w_ready;
   assign br_disp_tag   = w_free_idx;
   assign snapshot      = w_fire;
   assign flush         = w_mis;
   assign restore_tag   = w_mis ? res_tag : '0;
   assign kill_mask     = w_kill;
   assign busy_mask     = r_busy;
   assign err           = r_err;

endmodule
